// File: rtl/gcd_pkg.sv
// Shared types and ALU function codes for the GCD engine.
package gcd_pkg;

    // Controller states, in handshake/compute order.
    typedef enum logic [3:0] {
        IDLE,
        ACK_A,
        WAIT_B,
        CHK_A,
        CHK_B,
        CMP,
        SUB_A,
        SUB_B,
        OUT_A,
        OUT_B,
        DONE
    } state_t;

    // ALU function select.
    localparam logic [1:0] FN_AMB = 2'b00;  // A - B
    localparam logic [1:0] FN_BMA = 2'b01;  // B - A
    localparam logic [1:0] FN_A   = 2'b10;  // pass A
    localparam logic [1:0] FN_B   = 2'b11;  // pass B

endpackage

// File: rtl/gcd_fsm.sv
// Controller for the GCD engine: handshake sequencing plus subtract loop control.
module gcd_fsm
    import gcd_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_i,
    input  logic       z_i,
    input  logic       n_i,
    output logic       ack_o,
    output logic       abor_alu_o,
    output logic       ld_a_o,
    output logic       ld_b_o,
    output logic       ld_c_o,
    output logic [1:0] fn_o
);
    state_t state_q, state_d;

    // State register; reset wins over any in-flight computation.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and datapath controls; ack depends on state only, never on req.
    always_comb begin
        state_d    = state_q;
        ack_o      = 1'b0;
        abor_alu_o = 1'b0;
        ld_a_o     = 1'b0;
        ld_b_o     = 1'b0;
        ld_c_o     = 1'b0;
        fn_o       = FN_A;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    ld_a_o  = 1'b1;
                    state_d = ACK_A;
                end
            end
            ACK_A: begin
                ack_o = 1'b1;
                if (!req_i) state_d = WAIT_B;
            end
            WAIT_B: begin
                if (req_i) begin
                    ld_b_o  = 1'b1;
                    state_d = CHK_A;
                end
            end
            CHK_A: begin
                fn_o    = FN_A;
                state_d = z_i ? OUT_B : CHK_B;
            end
            CHK_B: begin
                fn_o    = FN_B;
                state_d = z_i ? OUT_A : CMP;
            end
            CMP: begin
                fn_o = FN_AMB;
                if (z_i)      state_d = OUT_A;
                else if (n_i) state_d = SUB_B;
                else          state_d = SUB_A;
            end
            SUB_A: begin
                fn_o       = FN_AMB;
                abor_alu_o = 1'b1;
                ld_a_o     = 1'b1;
                state_d    = CMP;
            end
            SUB_B: begin
                fn_o       = FN_BMA;
                abor_alu_o = 1'b1;
                ld_b_o     = 1'b1;
                state_d    = CMP;
            end
            OUT_A: begin
                fn_o    = FN_A;
                ld_c_o  = 1'b1;
                state_d = DONE;
            end
            OUT_B: begin
                fn_o    = FN_B;
                ld_c_o  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                ack_o = 1'b1;
                if (!req_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: rtl/gcd_parts.sv
// Datapath building blocks for the GCD engine: 2:1 mux, load-enable register, ALU.

module c_mux #(
    parameter int N = 16
) (
    input  logic         sel_i,
    input  logic [N-1:0] d0_i,
    input  logic [N-1:0] d1_i,
    output logic [N-1:0] y_o
);
    assign y_o = sel_i ? d1_i : d0_i;
endmodule

module c_reg #(
    parameter int N = 16
) (
    input  logic         clk_i,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);
    logic [N-1:0] q_q;

    // Operand storage; intentionally not reset, the controller always reloads it.
    always_ff @(posedge clk_i) begin
        if (en_i) q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

module c_alu
    import gcd_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [1:0]   fn_i,
    output logic [N-1:0] y_o,
    output logic         z_o,
    output logic         n_o
);
    // Operands keep MSB=0, so the result MSB of a subtraction acts as the borrow/sign flag.
    always_comb begin
        y_o = a_i;
        case (fn_i)
            FN_AMB:  y_o = a_i - b_i;
            FN_BMA:  y_o = b_i - a_i;
            FN_A:    y_o = a_i;
            FN_B:    y_o = b_i;
            default: y_o = a_i;
        endcase
    end

    assign z_o = (y_o == '0);
    assign n_o = y_o[N-1];
endmodule

// File: rtl/gcd_unit.sv
// GCD engine top: serial operand handshake, subtractive GCD datapath, registered result.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic [N-1:0] AB,
    output logic         ack,
    output logic [N-1:0] C
);
    logic [N-1:0] a_d, b_d, a_q, b_q, alu_y, c_q;
    logic         alu_z, alu_n, sel_alu, ld_a, ld_b, ld_c;
    logic [1:0]   fn;

    gcd_fsm u_fsm (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_i      (req),
        .z_i        (alu_z),
        .n_i        (alu_n),
        .ack_o      (ack),
        .abor_alu_o (sel_alu),
        .ld_a_o     (ld_a),
        .ld_b_o     (ld_b),
        .ld_c_o     (ld_c),
        .fn_o       (fn)
    );

    c_mux #(.N(N)) u_mux_a (.sel_i(sel_alu), .d0_i(AB), .d1_i(alu_y), .y_o(a_d));
    c_mux #(.N(N)) u_mux_b (.sel_i(sel_alu), .d0_i(AB), .d1_i(alu_y), .y_o(b_d));

    c_reg #(.N(N)) u_reg_a (.clk_i(clk), .en_i(ld_a), .d_i(a_d), .q_o(a_q));
    c_reg #(.N(N)) u_reg_b (.clk_i(clk), .en_i(ld_b), .d_i(b_d), .q_o(b_q));

    c_alu #(.N(N)) u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .fn_i (fn),
        .y_o  (alu_y),
        .z_o  (alu_z),
        .n_o  (alu_n)
    );

    // Result register: cleared by reset, otherwise holds until the next OUT_x load.
    always_ff @(posedge clk) begin
        if (reset)     c_q <= '0;
        else if (ld_c) c_q <= alu_y;
    end

    assign C = c_q;
endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: fixed vectors, corner sequences, randomized vs. Euclid model.
module tb_gcd_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic [15:0] AB;
    logic        ack;
    logic [15:0] C;

    int tests = 0;
    int fails = 0;
    logic [15:0] held_c;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        int          lat;
    } vec_t;

    vec_t tbl[6];

    gcd_unit #(.N(16)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .AB    (AB),
        .ack   (ack),
        .C     (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: Euclid by division.
    function automatic int ref_gcd(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Subtraction count = sum of Euclid quotients minus one (the last quotient ends at equality).
    function automatic int ref_lat(input int a, input int b);
        int x = a, y = b, t, s = 0;
        if (a == 0) return 2;
        if (b == 0) return 3;
        while (y != 0) begin
            s += x / y;
            t = x % y;
            x = y;
            y = t;
        end
        return 4 + 2 * (s - 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input logic val, input int bound, input string nm);
        for (int i = 0; i < bound && ack !== val; i++) @(negedge clk);
        chk(nm, {31'd0, ack}, {31'd0, val});
    endtask

    // One full transaction, called and returning at a negedge.
    // hold: extra ACK_A cycles with AB scrambled; drop: cycle after B load at which req falls early (-1 = never).
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int hold,
                           input int drop, input logic [15:0] expc, input int lat, input string nm);
        int cyc;
        bit got;
        req = 1'b1;
        AB  = a;
        wait_ack(1'b1, 4, {nm, "_ackA"});
        for (int h = 0; h < hold; h++) begin
            AB = 16'($urandom_range(0, 32767));
            @(negedge clk);
            chk({nm, "_ackA_hold"}, {31'd0, ack}, 32'd1);
            chk({nm, "_C_between"}, {16'd0, C}, {16'd0, held_c});
        end
        req = 1'b0;
        AB  = 16'($urandom_range(0, 32767));
        wait_ack(1'b0, 4, {nm, "_relA"});
        req = 1'b1;
        AB  = b;
        @(posedge clk);
        cyc = 0;
        got = 0;
        while (cyc <= lat + 20) begin
            @(negedge clk);
            AB = 16'($urandom_range(0, 32767));
            if (cyc == 1) chk({nm, "_C_busy"}, {16'd0, C}, {16'd0, held_c});
            if (ack === 1'b1) begin
                got = 1;
                break;
            end
            if (cyc == drop) req = 1'b0;
            @(posedge clk);
            cyc++;
        end
        chk({nm, "_ack"}, {31'd0, got}, 32'd1);
        chk({nm, "_lat"}, cyc, lat);
        chk({nm, "_C"}, {16'd0, C}, {16'd0, expc});
        req = 1'b0;
        @(negedge clk);
        chk({nm, "_rel"}, {31'd0, ack}, 32'd0);
        chk({nm, "_C_keep"}, {16'd0, C}, {16'd0, expc});
        held_c = expc;
    endtask

    initial begin
        logic [15:0] ra, rb;

        tbl[0] = '{a: 16'd12, b: 16'd8,  c: 16'd4, lat: 8};
        tbl[1] = '{a: 16'd0,  b: 16'd5,  c: 16'd5, lat: 2};
        tbl[2] = '{a: 16'd7,  b: 16'd0,  c: 16'd7, lat: 3};
        tbl[3] = '{a: 16'd0,  b: 16'd0,  c: 16'd0, lat: 2};
        tbl[4] = '{a: 16'd9,  b: 16'd9,  c: 16'd9, lat: 4};
        tbl[5] = '{a: 16'd21, b: 16'd13, c: 16'd1, lat: 16};

        reset = 1'b1;
        req   = 1'b0;
        AB    = '0;
        repeat (3) @(negedge clk);
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_C", {16'd0, C}, 32'd0);
        reset  = 1'b0;
        held_c = '0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_txn(tbl[i].a, tbl[i].b, 0, -1, tbl[i].c, tbl[i].lat, $sformatf("vec%0d", i));

        // Reset while in SUB_B for (12,18): CHK_A, CHK_B, CMP, then SUB_B after the third edge.
        req = 1'b1;
        AB  = 16'd12;
        wait_ack(1'b1, 4, "rst_ackA");
        req = 1'b0;
        wait_ack(1'b0, 4, "rst_relA");
        req = 1'b1;
        AB  = 16'd18;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        chk("midrst_ack", {31'd0, ack}, 32'd0);
        chk("midrst_C", {16'd0, C}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_idle_ack", {31'd0, ack}, 32'd0);
        held_c = '0;
        run_txn(16'd12, 16'd18, 0, -1, 16'd6, 8, "after_rst");

        // Back-to-back, second one holds req in ACK_A with AB changing.
        run_txn(16'd48, 16'd36, 0, -1, 16'd12, 10, "b2b0");
        run_txn(16'd35, 16'd14, 5, -1, 16'd7, 10, "b2b1");

        // req dropped during computation.
        run_txn(16'd12, 16'd8, 0, 2, 16'd4, 8, "drop");
        @(negedge clk);
        chk("drop_idle_ack", {31'd0, ack}, 32'd0);

        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom_range(0, 400));
            rb = 16'($urandom_range(0, 400));
            run_txn(ra, rb, 0, -1, 16'(ref_gcd(ra, rb)), ref_lat(ra, rb), $sformatf("rnd_%0d_%0d", ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
